// File: rtl/mimot_bus_reader.sv
// mimot_bus_reader: bus initiator that reads the two 8-bit encoder counters
// of the mimot CPLD over the multiplexed ALE/RD/AD bus. Each raw counter is
// unwrapped into a signed position accumulator. One start request performs
// one pass: address 0 then address 1, followed by a one-cycle done pulse.
module mimot_bus_reader #(
  parameter int SIZE  = 8,
  parameter int PSIZE = 16,
  parameter int T_ALE = 2,
  parameter int T_RD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ale,
  output logic             rd,
  output logic [SIZE-1:0]  ad_out,
  output logic             ad_oe,
  input  logic [SIZE-1:0]  ad_in,
  output logic [SIZE-1:0]  count0,
  output logic [SIZE-1:0]  count1,
  output logic [PSIZE-1:0] pos0,
  output logic [PSIZE-1:0] pos1
);

  // Phase counter must hold T_ALE-1 and T_RD-1.
  localparam int TMAX = (T_ALE > T_RD) ? T_ALE : T_RD;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    TURN,
    READ,
    RECOVER,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   phase;
  logic            chan;
  logic            primed;

  // Signed step since the previous read: the SIZE-bit difference is taken
  // mod 2^SIZE and treated as two's complement, so counter wrap unwraps.
  logic [SIZE-1:0]  diff0;
  logic [SIZE-1:0]  diff1;
  logic [PSIZE-1:0] next_pos0;
  logic [PSIZE-1:0] next_pos1;

  assign diff0     = ad_in - count0;
  assign diff1     = ad_in - count1;
  assign next_pos0 = pos0 + {{(PSIZE-SIZE){diff0[SIZE-1]}}, diff0};
  assign next_pos1 = pos1 + {{(PSIZE-SIZE){diff1[SIZE-1]}}, diff1};

  // Bus sequencer: every bus pin is a registered output of this FSM, so the
  // strobes are glitch-free and ad_oe/rd never overlap.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values of state, phase and the outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the async reset returns the bus to its safe idle levels
    // immediately, without waiting for a clock edge.
    if (!rst) begin
      state  <= IDLE;
      phase  <= '0;
      chan   <= 1'b0;
      primed <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ale    <= 1'b0;
      rd     <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
      count0 <= '0;
      count1 <= '0;
      pos0   <= '0;
      pos1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ADDR;
            chan   <= 1'b0;
            busy   <= 1'b1;
            ale    <= 1'b1;
            ad_oe  <= 1'b1;
            ad_out <= '0;
            phase  <= CW'(T_ALE - 1);
          end
        end

        ADDR: begin
          if (phase == '0) begin
            state <= HOLD;
            ale   <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        // Address stays driven one cycle past the ALE falling edge.
        HOLD: begin
          state <= TURN;
          ad_oe <= 1'b0;
        end

        // Bus turnaround: AD released, read strobe not yet asserted.
        TURN: begin
          state <= READ;
          rd    <= 1'b0;
          phase <= CW'(T_RD - 1);
        end

        READ: begin
          if (phase == '0) begin
            state <= RECOVER;
            rd    <= 1'b1;
            if (!chan) begin
              count0 <= ad_in;
              if (primed) pos0 <= next_pos0;
            end else begin
              count1 <= ad_in;
              if (primed) pos1 <= next_pos1;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end

        RECOVER: begin
          if (!chan) begin
            state  <= ADDR;
            chan   <= 1'b1;
            ale    <= 1'b1;
            ad_oe  <= 1'b1;
            ad_out <= SIZE'(1);
            phase  <= CW'(T_ALE - 1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          primed <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimot_bus_reader.sv
// tb_mimot_bus_reader: random and directed passes against a behavioural
// responder and an unwrap model. The driver pushes the expected result of
// each pass into a queue; an independent monitor pops it on every done.
// A protocol watcher checks bus timing on every cycle.
module tb_mimot_bus_reader;

  localparam int SIZE  = 8;
  localparam int PSIZE = 16;
  localparam int T_ALE = 2;
  localparam int T_RD  = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             ale;
  logic             rd;
  logic [SIZE-1:0]  ad_out;
  logic             ad_oe;
  logic [SIZE-1:0]  ad_in;
  logic [SIZE-1:0]  count0;
  logic [SIZE-1:0]  count1;
  logic [PSIZE-1:0] pos0;
  logic [PSIZE-1:0] pos1;

  mimot_bus_reader #(
    .SIZE (SIZE),
    .PSIZE(PSIZE),
    .T_ALE(T_ALE),
    .T_RD (T_RD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ale   (ale),
    .rd    (rd),
    .ad_out(ad_out),
    .ad_oe (ad_oe),
    .ad_in (ad_in),
    .count0(count0),
    .count1(count1),
    .pos0  (pos0),
    .pos1  (pos1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int ale_rises  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- responder (CPLD counter side) ----------------
  logic [SIZE-1:0] resp [2];
  logic            lat;
  logic [SIZE-1:0] junk;
  logic [SIZE-1:0] addr_q [$];

  initial begin
    lat  = 1'b0;
    junk = 8'hA5;
    resp[0] = '0;
    resp[1] = '0;
  end

  always @(negedge ale) begin
    if (rst) begin
      lat = ad_out[0];
      addr_q.push_back(ad_out);
    end
  end

  always @(posedge clk) junk = 8'($urandom);

  // Bus floats to junk unless the responder is being read.
  assign ad_in = rd ? junk : resp[lat];

  // ---------------- reference model ----------------
  typedef struct {
    logic [SIZE-1:0]  c0;
    logic [SIZE-1:0]  c1;
    logic [PSIZE-1:0] p0;
    logic [PSIZE-1:0] p1;
  } exp_t;

  exp_t exp_q [$];
  bit   m_primed;
  int   m_cnt [2];
  int   m_pos [2];

  task automatic model_reset();
    m_primed = 0;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      m_pos[c] = 0;
    end
  endtask

  // One pass: the step is the shortest signed distance between readings.
  task automatic model_push();
    exp_t e;
    int   d;
    for (int c = 0; c < 2; c++) begin
      if (m_primed) begin
        d = int'(resp[c]) - m_cnt[c];
        if (d > 127) d -= 256;
        else if (d < -128) d += 256;
        m_pos[c] = ((m_pos[c] + d) % 65536 + 65536) % 65536;
      end
      m_cnt[c] = int'(resp[c]);
    end
    m_primed = 1;
    e.c0 = SIZE'(m_cnt[0]);
    e.c1 = SIZE'(m_cnt[1]);
    e.p0 = PSIZE'(m_pos[0]);
    e.p1 = PSIZE'(m_pos[1]);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor: scoreboard pop on done ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("count0", count0, e.c0);
        check("count1", count1, e.c1);
        check("pos0", pos0, e.p0);
        check("pos1", pos1, e.p1);
        check("addr_cnt", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
          check("addr_ch0", addr_q[0], 0);
          check("addr_ch1", addr_q[1], 1);
        end
      end
      addr_q.delete();
    end
  end

  // ---------------- bus protocol watcher ----------------
  logic            p_ale  = 1'b0;
  logic            p_done = 1'b0;
  int              rd_low = 0;
  int              done_w = 0;
  logic [SIZE-1:0] aref   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      p_ale  = 1'b0;
      p_done = 1'b0;
      rd_low = 0;
      done_w = 0;
    end else begin
      check("oe_during_rd", {31'b0, ad_oe & ~rd}, 0);
      if (!rd) rd_low++;
      else if (rd_low != 0) begin
        check("rd_len", rd_low, T_RD);
        rd_low = 0;
      end
      if (ale && !p_ale) begin
        aref = ad_out;
        ale_rises++;
      end
      if (ale || p_ale) begin
        check("addr_stable", ad_out, aref);
        check("addr_oe", ad_oe, 1);
      end
      if (done) done_w++;
      else if (p_done) begin
        check("done_width", done_w, 1);
        done_w = 0;
      end
      p_ale  = ale;
      p_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'b0, busy}, 0);
  endtask

  // Runs one pass; pulse_at (1..15) pulses start mid-pass, 0 means none.
  task automatic run_pass(input int pulse_at);
    int k;
    bit seen;
    wait_idle();
    start = 1'b1;
    model_push();
    @(negedge clk);
    start = 1'b0;
    k    = 1;
    seen = 0;
    while (k <= 40 && !seen) begin
      if (done) seen = 1;
      else begin
        start = (k == pulse_at);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check("done_latency", seen ? k : 0, 17);
    check("busy_in_done", {31'b0, busy}, 1);
    @(negedge clk);
    check("busy_after_done", {31'b0, busy}, 0);
  endtask

  initial begin
    int t [3];
    int a0;
    int n;
    logic prd;
    bit  seen;

    rst   = 1'b0;
    start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ale", {31'b0, ale}, 0);
    check("rst_rd", {31'b0, rd}, 1);
    check("rst_oe", {31'b0, ad_oe}, 0);
    check("rst_ad_out", ad_out, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_count0", count0, 0);
    check("rst_count1", count1, 0);
    check("rst_pos0", pos0, 0);
    check("rst_pos1", pos1, 0);
    rst = 1'b1;

    // First pass is unprimed: counts load, positions stay zero.
    resp[0] = 8'h10;
    resp[1] = 8'hF0;
    run_pass(0);
    check("first_pos0", pos0, 0);
    check("first_pos1", pos1, 0);

    resp[0] = 8'h15;
    resp[1] = 8'hEB;
    run_pass(0);
    check("step_pos0", pos0, 16'h0005);
    check("step_pos1", pos1, 16'hFFFB);

    // Counter wrap in both directions.
    resp[0] = 8'hFE;
    resp[1] = 8'h02;
    run_pass(0);
    resp[0] = 8'h03;
    resp[1] = 8'hFC;
    run_pass(7);

    // Random passes with idle gaps and stray start pulses.
    for (int i = 0; i < 50; i++) begin
      resp[0] = 8'($urandom);
      resp[1] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pass(int'($urandom_range(0, 15)));
    end

    // start held high: back-to-back passes every 18 cycles.
    wait_idle();
    a0 = ale_rises;
    start = 1'b1;
    for (int i = 0; i < 3; i++) model_push();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      seen = 0;
      while (n < 40 && !seen) begin
        @(negedge clk);
        n++;
        if (done) seen = 1;
      end
      check("b2b_done_seen", {31'b0, seen}, 1);
      t[i] = cyc;
      if (i == 2) start = 1'b0;
    end
    check("b2b_period_a", t[1] - t[0], 18);
    check("b2b_period_b", t[2] - t[1], 18);
    repeat (25) @(negedge clk);
    check("b2b_idle", {31'b0, busy}, 0);
    check("b2b_ale_pulses", ale_rises - a0, 6);

    // Reset during channel 1 READ.
    resp[0] = 8'h33;
    resp[1] = 8'h44;
    wait_idle();
    start = 1'b1;
    model_push();
    @(negedge clk);
    start = 1'b0;
    n   = 0;
    prd = 1'b1;
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(negedge clk);
      if (!rd && prd) n++;
      prd = rd;
    end
    check("ch1_read_reached", n, 2);
    #2 rst = 1'b0;
    #1;
    check("arst_rd", {31'b0, rd}, 1);
    check("arst_ale", {31'b0, ale}, 0);
    check("arst_oe", {31'b0, ad_oe}, 0);
    check("arst_count0", count0, 0);
    check("arst_count1", count1, 0);
    check("arst_pos0", pos0, 0);
    check("arst_pos1", pos1, 0);
    exp_q.delete();
    addr_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Next pass is unprimed again.
    resp[0] = 8'h40;
    resp[1] = 8'h80;
    run_pass(0);
    check("post_rst_pos0", pos0, 0);
    check("post_rst_pos1", pos1, 0);
    check("post_rst_count1", count1, 8'h80);

    repeat (5) @(negedge clk);
    check("pending_expect", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
